pair_judge: RTL and testbench

Pair-resolution responder for the 16-cell memory game. It receives the card selections made by the cursor/selection logic (cell index plus the cell's hidden label) and decides, after a visible hold time, whether the two picks form a pair. It drives the `par` / flip-back feedback back to the cells, keeps per-player scores and the turn, and asserts end-of-game with the winner.

---
 rtl/pair_judge_pkg.sv | 29 ++
 rtl/pair_judge_hold_timer.sv | 33 +++
 rtl/pair_judge.sv | 207 ++++++++++++++++++++
 tb/tb_pair_judge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_judge_pkg.sv
// Shared state type, board geometry and winner codes for the memory-game pair judge.
package memgame_pkg;

  localparam int unsigned CELL_W  = 4;
  localparam int unsigned LABEL_W = 4;
  localparam int unsigned NCELLS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ONE,
    HOLD,
    RESOLVE,
    DONE
  } judge_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  function automatic logic [1:0] winner_code(input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0] w;
    if (s0 > s1)      w = WIN_P0;
    else if (s1 > s0) w = WIN_P1;
    else              w = WIN_TIE;
    return w;
  endfunction

endpackage

// File: rtl/pair_judge_hold_timer.sv
// Loadable down-counter; done is high for the single cycle the loaded count expires.
module hold_timer
  import memgame_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         run;

  // A load of N gives done N+1 cycles later; loading while running restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/pair_judge.sv
// Pair-resolution responder for the 16-cell memory game.
// Optional second-pick timeout is compiled in with `define PAIR_JUDGE_TIMEOUT_EN.
module pair_judge
  import memgame_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned NPAIRS         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [CELL_W-1:0]  sel_idx,
  input  logic [LABEL_W-1:0] sel_label,
  output logic               par,
  output logic               flip_back,
  output logic [CELL_W-1:0]  idx_a,
  output logic [CELL_W-1:0]  idx_b,
  output logic               player,
  output logic [3:0]         score0,
  output logic [3:0]         score1,
  output logic [NCELLS-1:0]  matched,
  output logic               busy,
  output logic               finish,
  output logic [1:0]         winner
);

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
`ifdef PAIR_JUDGE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [3:0] SCORE_MAX = 4'(NPAIRS);
  localparam logic [4:0] PAIRS_TGT = 5'(NPAIRS);

  judge_state_t state_q, state_n;

  logic               par_q, par_n;
  logic               flip_q, flip_n;
  logic [CELL_W-1:0]  idx_a_q, idx_a_n;
  logic [CELL_W-1:0]  idx_b_q, idx_b_n;
  logic [LABEL_W-1:0] label_a_q, label_a_n;
  logic [LABEL_W-1:0] label_b_q, label_b_n;
  logic               player_q, player_n;
  logic [3:0]         score0_q, score0_n;
  logic [3:0]         score1_q, score1_n;
  logic [NCELLS-1:0]  matched_q, matched_n;
  logic [4:0]         pairs_q, pairs_n;
  logic               busy_q, busy_n;
  logic               finish_q, finish_n;
  logic [1:0]         winner_q, winner_n;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;
  logic               take;
  logic               cell_free;

  hold_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Selections coinciding with a par/flip_back pulse are dropped so the cells settle first.
  assign take      = sel_valid && !par_q && !flip_q;
  assign cell_free = !matched_q[sel_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    par_n     = 1'b0;
    flip_n    = 1'b0;
    idx_a_n   = idx_a_q;
    idx_b_n   = idx_b_q;
    label_a_n = label_a_q;
    label_b_n = label_b_q;
    player_n  = player_q;
    score0_n  = score0_q;
    score1_n  = score1_q;
    matched_n = matched_q;
    pairs_n   = pairs_q;
    busy_n    = busy_q;
    finish_n  = finish_q;
    winner_n  = winner_q;
    tmr_load  = 1'b0;
    tmr_val   = HOLD_LD;

    unique case (state_q)
      IDLE: begin
        if (take && cell_free) begin
          idx_a_n   = sel_idx;
          label_a_n = sel_label;
          state_n   = ONE;
`ifdef PAIR_JUDGE_TIMEOUT_EN
          tmr_load  = 1'b1;
          tmr_val   = TO_LD;
`endif
        end
      end

      ONE: begin
        if (take && cell_free && (sel_idx != idx_a_q)) begin
          idx_b_n   = sel_idx;
          label_b_n = sel_label;
          busy_n    = 1'b1;
          tmr_load  = 1'b1;
          state_n   = HOLD;
        end
`ifdef PAIR_JUDGE_TIMEOUT_EN
        else if (tmr_done) begin
          flip_n   = 1'b1;
          idx_b_n  = idx_a_q;
          player_n = ~player_q;
          state_n  = IDLE;
        end
`endif
      end

      HOLD: begin
        if (tmr_done) state_n = RESOLVE;
      end

      RESOLVE: begin
        busy_n = 1'b0;
        if (label_a_q == label_b_q) begin
          par_n              = 1'b1;
          matched_n[idx_a_q] = 1'b1;
          matched_n[idx_b_q] = 1'b1;
          pairs_n            = pairs_q + 5'd1;
          if (!player_q) begin
            if (score0_q < SCORE_MAX) score0_n = score0_q + 4'd1;
          end else begin
            if (score1_q < SCORE_MAX) score1_n = score1_q + 4'd1;
          end
        end else begin
          flip_n   = 1'b1;
          player_n = ~player_q;
        end
        state_n = (pairs_n >= PAIRS_TGT) ? DONE : IDLE;
      end

      DONE: begin
        finish_n = 1'b1;
        winner_n = winner_code(score0_q, score1_q);
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q     <= 1'b0;
      flip_q    <= 1'b0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      label_a_q <= '0;
      label_b_q <= '0;
      player_q  <= 1'b0;
      score0_q  <= '0;
      score1_q  <= '0;
      matched_q <= '0;
      pairs_q   <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      winner_q  <= WIN_NONE;
    end else begin
      par_q     <= par_n;
      flip_q    <= flip_n;
      idx_a_q   <= idx_a_n;
      idx_b_q   <= idx_b_n;
      label_a_q <= label_a_n;
      label_b_q <= label_b_n;
      player_q  <= player_n;
      score0_q  <= score0_n;
      score1_q  <= score1_n;
      matched_q <= matched_n;
      pairs_q   <= pairs_n;
      busy_q    <= busy_n;
      finish_q  <= finish_n;
      winner_q  <= winner_n;
    end
  end

  assign par       = par_q;
  assign flip_back = flip_q;
  assign idx_a     = idx_a_q;
  assign idx_b     = idx_b_q;
  assign player    = player_q;
  assign score0    = score0_q;
  assign score1    = score1_q;
  assign matched   = matched_q;
  assign busy      = busy_q;
  assign finish    = finish_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pair_judge.sv
// Randomized bench for pair_judge against a turn-level game model.
`timescale 1ns/1ps
module tb_pair_judge;
  import memgame_pkg::*;

  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 10;
  localparam int unsigned NP   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_idx = '0;
  logic [3:0] sel_label = '0;
  logic       par, flip_back, player, busy, finish;
  logic [3:0] idx_a, idx_b, score0, score1;
  logic [15:0] matched;
  logic [1:0] winner;

  int n_tests = 0;
  int n_fail  = 0;

  pair_judge #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .NPAIRS         (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .sel_label (sel_label),
    .par       (par),
    .flip_back (flip_back),
    .idx_a     (idx_a),
    .idx_b     (idx_b),
    .player    (player),
    .score0    (score0),
    .score1    (score1),
    .matched   (matched),
    .busy      (busy),
    .finish    (finish),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  // Game model: board occupancy, scores, whose turn, pending picks.
  bit m_matched[16];
  int m_s0, m_s1, m_player, m_pairs, m_phase, m_a, m_b, m_la, m_lb;
  bit m_over;
  int board[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 16; i++) if (m_matched[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_winner();
    if (!m_over)          return 0;
    else if (m_s0 > m_s1) return 1;
    else if (m_s1 > m_s0) return 2;
    else                  return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_matched[i] = 1'b0;
    m_s0 = 0; m_s1 = 0; m_player = 0; m_pairs = 0; m_phase = 0;
    m_a = 0; m_b = 0; m_la = 0; m_lb = 0; m_over = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_par"},     par, 0);
    check({tag, "_flip"},    flip_back, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_finish"},  finish, 0);
    check({tag, "_idx_a"},   idx_a, 0);
    check({tag, "_idx_b"},   idx_b, 0);
    check({tag, "_player"},  player, 0);
    check({tag, "_score0"},  score0, 0);
    check({tag, "_score1"},  score1, 0);
    check({tag, "_matched"}, matched, 0);
    check({tag, "_winner"},  winner, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst = 1'b1;
    model_reset();
  endtask

  function automatic int free_cell(input int excl);
    int c[$];
    for (int i = 0; i < 16; i++) if (!m_matched[i] && i != excl) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int partner(input int a);
    for (int i = 0; i < 16; i++) if (i != a && board[i] == board[a]) return i;
    return a;
  endfunction

  function automatic int diff_cell(input int a);
    int c[$];
    for (int i = 0; i < 16; i++) if (!m_matched[i] && board[i] != board[a]) c.push_back(i);
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  task automatic shuffle_board();
    int j, t;
    for (int i = 0; i < 16; i++) board[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = board[i]; board[i] = board[j]; board[j] = t;
    end
  endtask

  task automatic pick(input int idx, input int lbl, output bit second);
    @(negedge clk);
    sel_valid = 1'b1; sel_idx = 4'(idx); sel_label = 4'(lbl);
    @(posedge clk); #1;
    sel_valid = 1'b0;
    second = 1'b0;
    if (!m_over && !m_matched[idx]) begin
      if (m_phase == 0) begin
        m_a = idx; m_la = lbl; m_phase = 1;
      end else if (idx != m_a) begin
        m_b = idx; m_lb = lbl; m_phase = 0; second = 1'b1;
      end
    end
    check("pick_idx_a", idx_a, m_a);
    check("pick_idx_b", idx_b, m_b);
    check("pick_busy", busy, second);
  endtask

  // Called right after the second pick; walks the hold, the pulse and the cycle after.
  task automatic resolve();
    bit hit;
    int d;
    for (int c = 1; c <= HOLD; c++) begin
      @(negedge clk);
      sel_valid = 1'($urandom_range(0, 1));
      sel_idx   = 4'($urandom_range(0, 15));
      sel_label = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      sel_valid = 1'b0;
      check("hold_busy", busy, 1);
      check("hold_pulse", {par, flip_back}, 0);
    end
    @(posedge clk); #1;
    hit = (m_la == m_lb);
    if (hit) begin
      m_matched[m_a] = 1'b1; m_matched[m_b] = 1'b1; m_pairs++;
      if (m_player == 0) begin if (m_s0 < NP) m_s0++; end
      else               begin if (m_s1 < NP) m_s1++; end
    end else begin
      m_player ^= 1;
    end
    m_over = (m_pairs == NP);
    check("res_par",     par, hit);
    check("res_flip",    flip_back, !hit);
    check("res_busy",    busy, 0);
    check("res_matched", matched, exp_mask());
    check("res_score0",  score0, m_s0);
    check("res_score1",  score1, m_s1);
    check("res_player",  player, m_player);
    check("res_idx_a",   idx_a, m_a);
    check("res_idx_b",   idx_b, m_b);
    d = free_cell(m_a);
    @(negedge clk);
    if (d >= 0) begin sel_valid = 1'b1; sel_idx = 4'(d); sel_label = 4'(m_la); end
    @(posedge clk); #1;
    sel_valid = 1'b0;
    check("post_pulse", {par, flip_back}, 0);
    check("drop_idx_a", idx_a, m_a);
    check("finish",     finish, m_over);
    check("winner",     winner, exp_winner());
  endtask

  task automatic turn(input bit want_hit);
    int a, b;
    bit s;
    a = free_cell(-1);
    b = want_hit ? partner(a) : diff_cell(a);
    pick(a, board[a], s);
    pick(b, board[b], s);
    if (s) resolve();
  endtask

  bit plan_full[11] = '{1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
  bit plan_tie[10]  = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

  initial begin
    #2_000_000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bit s;
    int a, b;
    model_reset();

    // Directed match, mismatch and illegal picks in one session.
    do_reset();
    pick(0, 1, s); pick(13, 1, s); resolve();
    check("match_mask", matched, 32'h2001);
    pick(1, 2, s); pick(2, 3, s); resolve();
    pick(13, 1, s);
    pick(5, 7, s); pick(5, 7, s);
    pick(0, 1, s);
    pick(6, 7, s); if (s) resolve();

    // Random full game: player 0 ends with 5 pairs, player 1 with 3.
    do_reset();
    shuffle_board();
    foreach (plan_full[i]) turn(plan_full[i]);
    check("full_winner", winner, 1);
    for (int i = 0; i < 3; i++) pick($urandom_range(0, 15), $urandom_range(0, 15), s);
    @(posedge clk); #1;
    check("full_hold_finish", finish, 1);
    check("full_hold_score0", score0, m_s0);

    // Random 4-4 game.
    do_reset();
    shuffle_board();
    foreach (plan_tie[i]) turn(plan_tie[i]);
    check("tie_winner", winner, 3);

    // Reset in the middle of HOLD.
    do_reset();
    shuffle_board();
    a = free_cell(-1); b = partner(a);
    pick(a, board[a], s); pick(b, board[b], s);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("midhold");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    for (int c = 0; c < HOLD + 4; c++) begin
      @(posedge clk); #1;
      check("after_abort_pulse", {par, flip_back}, 0);
      check("after_abort_busy", busy, 0);
    end

`ifdef PAIR_JUDGE_TIMEOUT_EN
    do_reset();
    pick(3, 4, s);
    for (int c = 1; c < TMO; c++) begin
      @(posedge clk); #1;
      check("tmo_wait_flip", flip_back, 0);
    end
    @(posedge clk); #1;
    m_b = m_a; m_player ^= 1; m_phase = 0;
    check("tmo_flip",   flip_back, 1);
    check("tmo_idx_b",  idx_b, m_b);
    check("tmo_player", player, m_player);
    @(posedge clk); #1;
    check("tmo_flip_end", flip_back, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
